shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_seq_if.sv | 28 ++
 rtl/shift_seq_step.sv | 45 ++++
 rtl/shift_seq.sv | 126 ++++++++++++
 tb/tb_shift_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared mode and FSM state encodings for the sequential shifter.
// Helpers classify a raw 3-bit mode code as legal and/or shifting.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_DIRECT = 3'b000,
    MODE_LSR    = 3'b001,
    MODE_LSL    = 3'b010,
    MODE_ASR    = 3'b011,
    MODE_ROR    = 3'b100,
    MODE_ROL    = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  function automatic logic is_legal_mode(input logic [2:0] m);
    return (m <= MODE_ROL);
  endfunction

  // Direct mode is legal but never enters SHIFT.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_LSR) && (m <= MODE_ROL);
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for shift_seq.
// master drives requests and consumes results; slave is the shifter side.
interface shift_seq_if #(
  parameter int SIZE = 8
);
  localparam int AMT_W = $clog2(SIZE);

  logic [SIZE-1:0]  DataIn;
  logic [AMT_W-1:0] amtIn;
  logic [2:0]       codeShift;
  logic             inValid;
  logic             inReady;
  logic [SIZE-1:0]  shiftOut;
  logic             outValid;
  logic             outReady;
  logic             errOut;

  modport master (
    output DataIn, amtIn, codeShift, inValid, outReady,
    input  inReady, shiftOut, outValid, errOut
  );

  modport slave (
    input  DataIn, amtIn, codeShift, inValid, outReady,
    output inReady, shiftOut, outValid, errOut
  );

endinterface

// File: rtl/shift_seq_step.sv
// One-position combinational shift/rotate for shift_seq; zero latency.
// Unknown or direct modes pass the value through with a zero out-bit.
module shift_step
  import shift_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] val_i,
  input  logic [2:0]      mode_i,
  output logic [SIZE-1:0] next_o,
  output logic            out_bit_o
);

  always_comb begin
    next_o    = val_i;
    out_bit_o = 1'b0;
    case (mode_i)
      MODE_LSR: begin
        next_o    = {1'b0, val_i[SIZE-1:1]};
        out_bit_o = val_i[0];
      end
      MODE_LSL: begin
        next_o    = {val_i[SIZE-2:0], 1'b0};
        out_bit_o = val_i[SIZE-1];
      end
      MODE_ASR: begin
        next_o    = {val_i[SIZE-1], val_i[SIZE-1:1]};
        out_bit_o = val_i[0];
      end
      MODE_ROR: begin
        next_o    = {val_i[0], val_i[SIZE-1:1]};
        out_bit_o = val_i[0];
      end
      MODE_ROL: begin
        next_o    = {val_i[SIZE-2:0], val_i[SIZE-1]};
        out_bit_o = val_i[SIZE-1];
      end
      default: begin
        next_o    = val_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter, one bit per cycle; result valid 1+amt cycles after the request cycle.
// inReady only in IDLE; result held in HOLD until outReady. SHIFT_SEQ_CARRY_EN adds carryOut.
module shift_seq
  import shift_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SHIFT_SEQ_CARRY_EN
  output logic        carryOut,
`endif
  shift_seq_if.slave  bus
);

  localparam int AMT_W = $clog2(SIZE);

  state_e           state_q, state_d;
  logic [SIZE-1:0]  shift_q, shift_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_ready;
  logic             out_valid;
  logic [SIZE-1:0]  step_next;
`ifdef SHIFT_SEQ_CARRY_EN
  logic             carry_q, carry_d;
  logic             step_bit;
`else
  logic             unused_step_bit;
`endif

  shift_step #(.SIZE(SIZE)) u_step (
    .val_i     (shift_q),
    .mode_i    (mode_q),
    .next_o    (step_next),
`ifdef SHIFT_SEQ_CARRY_EN
    .out_bit_o (step_bit)
`else
    .out_bit_o (unused_step_bit)
`endif
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
    carry_d   = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.inValid) begin
          shift_d = bus.DataIn;
          mode_d  = bus.codeShift;
          cnt_d   = bus.amtIn;
          err_d   = !is_legal_mode(bus.codeShift);
`ifdef SHIFT_SEQ_CARRY_EN
          carry_d = 1'b0;
`endif
          if ((bus.amtIn != '0) && is_shift_mode(bus.codeShift)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_SHIFT: begin
        shift_d = step_next;
        cnt_d   = cnt_q - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
        carry_d = step_bit;
`endif
        // The step taken at count 1 is the last one, so leave SHIFT on the same edge.
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (bus.outReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      mode_q  <= MODE_DIRECT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.shiftOut = shift_q;
  assign bus.errOut   = err_q;
`ifdef SHIFT_SEQ_CARRY_EN
  assign carryOut     = carry_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq (SIZE=8); checks values, latency, hold, reset and back-to-back.
// Carry checks are compiled in when SHIFT_SEQ_CARRY_EN is defined.
module tb_shift_seq;
  import shift_pkg::*;

  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_seq_if #(.SIZE(SIZE)) bus ();
`ifdef SHIFT_SEQ_CARRY_EN
  logic carryOut;
`endif

  shift_seq #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SHIFT_SEQ_CARRY_EN
    .carryOut (carryOut),
`endif
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for acceptance, then scramble the inputs.
  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m);
    int w = 0;
    while (!bus.inReady && w < 50) begin
      tick();
      w++;
    end
    chk("ready_wait", {63'd0, bus.inReady}, 64'd1);
    bus.DataIn    = d;
    bus.amtIn     = a;
    bus.codeShift = m;
    bus.inValid   = 1'b1;
    tick();
    bus.inValid   = 1'b0;
    bus.DataIn    = ~d;
    bus.amtIn     = ~a;
    bus.codeShift = 3'b111;
  endtask

  // Latency counts clock edges from the acceptance edge (inclusive) to outValid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.outValid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] d, input logic [2:0] a,
                     input logic [2:0] m, input logic [7:0] exp_val, input logic exp_err,
                     input int exp_lat, input logic exp_carry);
    int lat;
    issue(d, a, m);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_val"}, {56'd0, bus.shiftOut}, {56'd0, exp_val});
    chk({tag, "_err"}, {63'd0, bus.errOut}, {63'd0, exp_err});
    chk({tag, "_busy"}, {63'd0, bus.inReady}, 64'd0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk({tag, "_carry"}, {63'd0, carryOut}, {63'd0, exp_carry});
`else
    if (exp_carry === 1'bx) $display("unexpected carry expectation");
`endif
    release_out();
    chk({tag, "_done"}, {63'd0, bus.outValid}, 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    bus.DataIn    = '0;
    bus.amtIn     = '0;
    bus.codeShift = 3'b000;
    bus.inValid   = 1'b0;
    bus.outReady  = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", {63'd0, bus.outValid}, 64'd0);
    chk("rst_out", {56'd0, bus.shiftOut}, 64'd0);
    chk("rst_err", {63'd0, bus.errOut}, 64'd0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("rst_carry", {63'd0, carryOut}, 64'd0);
`endif
    rst_n = 1'b1;
    chk("rst_ready", {63'd0, bus.inReady}, 64'd1);

    // Main function, hand-computed vectors
    run("lsr_b4_3",  8'hB4, 3'd3, MODE_LSR,    8'h16, 1'b0, 4, 1'b1);
    run("asr_96_2",  8'h96, 3'd2, MODE_ASR,    8'hE5, 1'b0, 3, 1'b1);
    run("rol_81_1",  8'h81, 3'd1, MODE_ROL,    8'h03, 1'b0, 2, 1'b1);
    run("ror_81_7",  8'h81, 3'd7, MODE_ROR,    8'h03, 1'b0, 8, 1'b0);
    run("lsl_c3_7",  8'hC3, 3'd7, MODE_LSL,    8'h80, 1'b0, 8, 1'b1);
    run("lsl_5a_0",  8'h5A, 3'd0, MODE_LSL,    8'h5A, 1'b0, 1, 1'b0);
    run("dir_7e_4",  8'h7E, 3'd4, MODE_DIRECT, 8'h7E, 1'b0, 1, 1'b0);
    run("ill6_3c",   8'h3C, 3'd5, 3'b110,      8'h3C, 1'b1, 1, 1'b0);
    run("ill7_c3",   8'hC3, 3'd2, 3'b111,      8'hC3, 1'b1, 1, 1'b0);

    // Hold with outReady low while a competing request is offered
    issue(8'hF0, 3'd4, MODE_LSR);
    wait_valid(lat);
    chk("hold_lat", 64'(lat), 64'd5);
    for (int i = 0; i < 5; i++) begin
      bus.inValid   = 1'b1;
      bus.DataIn    = 8'h11;
      bus.amtIn     = 3'd0;
      bus.codeShift = MODE_DIRECT;
      tick();
      chk("hold_val", {56'd0, bus.shiftOut}, 64'h0F);
      chk("hold_ready", {63'd0, bus.inReady}, 64'd0);
      chk("hold_valid", {63'd0, bus.outValid}, 64'd1);
    end
    bus.inValid = 1'b0;
    release_out();
    chk("hold_done", {63'd0, bus.outValid}, 64'd0);
    chk("hold_idle", {63'd0, bus.inReady}, 64'd1);

    // Reset in the middle of SHIFT
    issue(8'hFF, 3'd7, MODE_LSR);
    tick();
    tick();
    chk("mid_valid", {63'd0, bus.outValid}, 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", {63'd0, bus.outValid}, 64'd0);
    chk("mrst_ready", {63'd0, bus.inReady}, 64'd1);
    chk("mrst_out", {56'd0, bus.shiftOut}, 64'd0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("mrst_carry", {63'd0, carryOut}, 64'd0);
`endif
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.outValid) seen++;
    end
    chk("mrst_stale", 64'(seen), 64'd0);

    // Back-to-back: request offered in HOLD with outReady=1 lands one cycle later
    issue(8'hA5, 3'd0, MODE_DIRECT);
    wait_valid(lat);
    chk("b2b_first", {56'd0, bus.shiftOut}, 64'hA5);
    bus.outReady  = 1'b1;
    bus.inValid   = 1'b1;
    bus.DataIn    = 8'h5A;
    bus.amtIn     = 3'd1;
    bus.codeShift = MODE_LSL;
    tick();
    bus.outReady  = 1'b0;
    chk("b2b_idle", {63'd0, bus.inReady}, 64'd1);
    chk("b2b_gap", {63'd0, bus.outValid}, 64'd0);
    tick();
    bus.inValid   = 1'b0;
    bus.DataIn    = 8'h00;
    chk("b2b_taken", {63'd0, bus.inReady}, 64'd0);
    wait_valid(lat);
    chk("b2b_lat", 64'(lat), 64'd2);
    chk("b2b_val", {56'd0, bus.shiftOut}, 64'hB4);
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
